// File: rtl/chu_io_pkg.sv
// Shared widths, address field positions and FSM state type for the CPU IO bridge.
package chu_io_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SLOT_W   = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SLOT_LSB = 7;
  localparam int unsigned REG_LSB  = 2;
  localparam int unsigned WIN_LSB  = 24;
  localparam int unsigned WIN_W    = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} bridge_state_t;

  function automatic logic [SLOT_W-1:0] addr_slot(input logic [ADDR_W-1:0] addr);
    return addr[SLOT_LSB +: SLOT_W];
  endfunction

  function automatic logic [REG_W-1:0] addr_reg(input logic [ADDR_W-1:0] addr);
    return addr[REG_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/chu_slot_rdmux.sv
// Selects one slot's 32-bit read word from the flattened slot read bus; unknown slots read 0.
module chu_slot_rdmux
  import chu_io_pkg::*;
#(
  parameter int unsigned N_SLOTS = 64
) (
  input  logic [SLOT_W-1:0]         sel,
  input  logic [N_SLOTS*DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]         word_c
);

  always_comb begin
    word_c = '0;
    for (int k = 0; k < int'(N_SLOTS); k++) begin
      if (sel == SLOT_W'(k)) word_c = rd_data[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/chu_io_bridge.sv
// Registered bridge from the CPU strobe IO bus onto the one-hot MMIO slot bus.
module chu_io_bridge
  import chu_io_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hC000_0000,
  parameter int unsigned       N_SLOTS   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      io_addr_strobe,
  input  logic                      io_read_strobe,
  input  logic                      io_write_strobe,
  input  logic [ADDR_W-1:0]         io_address,
  input  logic [3:0]                io_byte_enable,
  input  logic [DATA_W-1:0]         io_write_data,
  output logic [DATA_W-1:0]         io_read_data,
  output logic                      io_ready,
  output logic                      io_err,
  output logic                      io_ovr,
  output logic [N_SLOTS-1:0]        slot_cs,
  output logic                      slot_read,
  output logic                      slot_write,
  output logic [REG_W-1:0]          slot_addr,
  output logic [DATA_W-1:0]         slot_wr_data,
  input  logic [N_SLOTS*DATA_W-1:0] slot_rd_data
);

  bridge_state_t       state;
  logic [SLOT_W-1:0]   lat_slot;
  logic                lat_read;
  logic                lat_hit;

  logic                accept_c;
  logic                req_hit_c;
  logic [SLOT_W-1:0]   req_slot_c;
  logic [DATA_W-1:0]   mux_word_c;
  logic                unused_bits_c;

  // Full-word bus: byte lanes, low address bits and the window's lower bits carry no meaning.
  assign unused_bits_c = ^{io_byte_enable, io_address[WIN_LSB-1:SLOT_LSB+SLOT_W],
                           io_address[REG_LSB-1:0]};

  assign req_slot_c = addr_slot(io_address);
  assign accept_c   = io_addr_strobe & (io_read_strobe ^ io_write_strobe);
  assign req_hit_c  = (io_address[WIN_LSB +: WIN_W] == BASE_ADDR[WIN_LSB +: WIN_W]) &&
                      (32'(req_slot_c) < N_SLOTS);

  chu_slot_rdmux #(.N_SLOTS(N_SLOTS)) u_rdmux (
    .sel     (lat_slot),
    .rd_data (slot_rd_data),
    .word_c  (mux_word_c)
  );

  // Request FSM; slot strobes and CPU completion are single-cycle registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lat_slot     <= '0;
      lat_read     <= 1'b0;
      lat_hit      <= 1'b0;
      io_read_data <= '0;
      io_ready     <= 1'b0;
      io_err       <= 1'b0;
      io_ovr       <= 1'b0;
      slot_cs      <= '0;
      slot_read    <= 1'b0;
      slot_write   <= 1'b0;
      slot_addr    <= '0;
      slot_wr_data <= '0;
    end else begin
      slot_cs    <= '0;
      slot_read  <= 1'b0;
      slot_write <= 1'b0;
      io_ready   <= 1'b0;
      io_err     <= 1'b0;

      if (io_addr_strobe && (state != IDLE)) io_ovr <= 1'b1;

      case (state)
        IDLE: begin
          if (accept_c) begin
            lat_slot     <= req_slot_c;
            lat_read     <= io_read_strobe;
            lat_hit      <= req_hit_c;
            slot_addr    <= addr_reg(io_address);
            slot_wr_data <= io_write_data;
            slot_cs      <= req_hit_c ? (N_SLOTS'(1) << req_slot_c) : '0;
            slot_read    <= req_hit_c & io_read_strobe;
            slot_write   <= req_hit_c & io_write_strobe;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          io_read_data <= (lat_hit && lat_read) ? mux_word_c : '0;
          io_ready     <= 1'b1;
          io_err       <= ~lat_hit;
          state        <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/chu_io_bridge.md
Name: chu_io_bridge

Overview:
Registered bridge between the CPU's strobe-based IO bus and the MMIO slot bus that peripheral cores such as timers, GPIO and UART sit on. It latches each CPU request and decodes the slot and register fields. It then issues a single-cycle slot access with one-hot cs and returns captured read data with an io_ready pulse. It sits directly upstream of every slot core and owns the shared read/write/addr/wr_data lines.

Parameters:
BASE_ADDR, 32'hC000_0000, bridge window; a request hits when io_address[31:24] == BASE_ADDR[31:24]
N_SLOTS, 64, number of slots implemented (1..64); slot index >= N_SLOTS counts as a miss

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
io_addr_strobe  in  1  CPU request valid, one-cycle pulse
io_read_strobe  in  1  read qualifier, coincident with io_addr_strobe
io_write_strobe  in  1  write qualifier, coincident with io_addr_strobe
io_address  in  32  byte address
io_byte_enable  in  4  byte lanes; ignored, all writes are full-word
io_write_data  in  32  write data
io_read_data  out  32  read data, valid while io_ready=1
io_ready  out  1  one-cycle completion pulse
io_err  out  1  high with io_ready when the request missed
io_ovr  out  1  sticky flag: a strobe arrived while busy
slot_cs  out  N_SLOTS  one-hot slot select
slot_read  out  1  read pulse to slots
slot_write  out  1  write pulse to slots
slot_addr  out  5  register index within slot
slot_wr_data  out  32  write data to slots
slot_rd_data  in  N_SLOTS*32  flattened slot read data; slot k occupies [32k+31:32k]

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; all latches 0.
- Address decode: slot = io_address[12:7]; reg = io_address[6:2]; io_address[1:0] ignored.
- Hit condition: the window matches AND slot < N_SLOTS.
- FSM states are IDLE, ISSUE and RESP.
- IDLE: when io_addr_strobe=1 and (read xor write strobe), latch address, data, type and hit; go to ISSUE.
  - Strobe with both or neither qualifier: ignored, stay IDLE.
- ISSUE (exactly one cycle):
  - Hit: slot_cs[slot]=1 and slot_read or slot_write=1.
  - slot_addr and slot_wr_data driven from the latches.
  - Miss: slot_cs all 0; read and write stay low.
  - On a hit read, the selected slot_rd_data is sampled at the end of the cycle; otherwise the data register loads 0.
  - Next state: RESP.
- RESP (exactly one cycle): io_ready=1, io_read_data=captured data, io_err=~hit; go to IDLE.
- Latency: strobe in cycle t, slot access in cycle t+1, io_ready in cycle t+2. Throughput is one request per 3 cycles.
- Outputs outside their active state:
  - slot_cs, slot_read, slot_write are 0 outside ISSUE.
  - slot_addr and slot_wr_data hold their last latched value.
  - io_ready and io_err are 0 outside RESP.
  - io_read_data holds its last value.
- Strobe while in ISSUE or RESP: request dropped; io_ovr set and held until reset.
- Byte enables: writes ignore io_byte_enable and always write the full word; reads return the full word.
- Reset mid-operation: drop the request immediately; no io_ready is generated for it.

Decomposition:
- Package chu_io_pkg: SLOT_W=6, REG_W=5, DATA_W=32, typedef enum {IDLE, ISSUE, RESP} bridge_state_t, and the slot/register bit-field positions.
- Sub-module chu_slot_rdmux: combinational selection of a 32-bit word from the flattened slot_rd_data by slot index; out-of-range index returns 0.

Test Plan:
- Write hit: addr 0xC000_0088 (slot 1, reg 2), data 0x0000_0003 -> cycle t+1: slot_cs=1<<1, slot_write=1, slot_addr=2, slot_wr_data=3; cycle t+2: io_ready=1, io_err=0; no other cs asserted.
- Read hit: slot 1 drives 0x0000_1234; read addr 0xC000_0080 -> slot_read=1 for one cycle at t+1; io_read_data=0x0000_1234 with io_ready at t+2.
- Miss, window: read addr 0x8000_0000 -> no slot_cs or slot_read; at t+2 io_ready=1, io_err=1, io_read_data=0.
- Miss, slot range: N_SLOTS=8, read slot 9 -> no slot_cs or slot_read; at t+2 io_ready=1, io_err=1, io_read_data=0.
- Busy strobe: second strobe at t+1 -> dropped; io_ovr=1 from t+2 and stays set; only one io_ready occurs.
- Back-to-back: write at t, read at t+3 -> two io_ready pulses at t+2 and t+5; the read returns the slot's current value.
- Reset mid-op: assert rst_n=0 during ISSUE -> slot_cs, io_ready, io_ovr and io_read_data go to 0 asynchronously; after release the FSM is in IDLE and accepts a new request normally.
